mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_array.sv | 27 ++
 rtl/mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and word
// geometry used by mem_responder and mem_array.
package mem_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage: synchronous write port, combinational read port.
// Contents start at zero and are never cleared by reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory slave with programmable wait states, address error
// decode and an optional mailbox word (enabled by defining MEM_MAILBOX_EN).
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned WAIT_CYCLES  = DEF_WAIT_CYCLES,
  parameter logic [31:0] MAILBOX_ADDR = 32'd84
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              done,
  output logic [WORD_W-1:0] mbox_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              in_resp;
  logic              err_c;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] resp_rdata;

  assign in_resp    = (state_q == S_RESP);
  assign err_c      = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign mem_we     = in_resp && we_q && !err_c;
  assign resp_rdata = err_c ? '0 : mem_rdata;

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .raddr (addr_q[AW+1:2]),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!we_q) begin
          rdata_d = resp_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // rdata is live from memory during a read response and holds otherwise
  assign ready = in_resp;
  assign err   = in_resp && err_c;
  assign rdata = (in_resp && !we_q) ? resp_rdata : rdata_q;

`ifdef MEM_MAILBOX_EN
  logic              done_q, done_d;
  logic [WORD_W-1:0] mbox_q, mbox_d;

  always_comb begin
    done_d = done_q;
    mbox_d = mbox_q;
    if (mem_we && (addr_q == MAILBOX_ADDR)) begin
      done_d = 1'b1;
      mbox_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= 1'b0;
      mbox_q <= '0;
    end else begin
      done_q <= done_d;
      mbox_q <= mbox_d;
    end
  end

  assign done      = done_q;
  assign mbox_data = mbox_q;
`else
  assign done      = 1'b0;
  assign mbox_data = '0;
`endif

endmodule
